// File: rtl/pivot_row_swap_pkg.sv
// Shared definitions for the pivot row exchange and its column-scan neighbours.
// Holds the FSM state encoding, default matrix geometry and the row-index width helper.
package pivot_row_swap_pkg;

   localparam int PRS_MAT_SIZE = 5;
   localparam int PRS_DATWIDTH = 64;

   // One extra bit so out-of-range winner indices stay representable.
   function automatic int prs_idx_w(input int mat_size);
      return $clog2(mat_size) + 1;
   endfunction

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_B  = 3'd2,
      CAP_B = 3'd3,
      WR_A  = 3'd4,
      WR_B  = 3'd5,
      DONE  = 3'd6
   } prs_state_e;

endpackage

// File: rtl/pivot_row_swap.sv
// Exchanges the target row with the pivot row in row memory after a pivot search completes.
// Latency accept->swapDone: 6 cycles for a swap, 1 for skip/singular; matchDone is not acknowledged while busy.
module pivot_row_swap
   import pivot_row_swap_pkg::*;
#(
   parameter int MAT_SIZE = PRS_MAT_SIZE,
   parameter int DATWIDTH = PRS_DATWIDTH,
   parameter int ROWWIDTH = 2 * MAT_SIZE * DATWIDTH
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [prs_idx_w(MAT_SIZE)-1:0] opCnt,
   input  logic                           matchDone,
   input  logic                           error,
   input  logic [prs_idx_w(MAT_SIZE)-1:0] winnerIndex,
   output logic                           matchDoneRst,
   output logic                           rowRdEn,
   output logic [prs_idx_w(MAT_SIZE)-1:0] rowRdAddr,
   input  logic [ROWWIDTH-1:0]            rowRdData,
   output logic                           rowWrEn,
   output logic [prs_idx_w(MAT_SIZE)-1:0] rowWrAddr,
   output logic [ROWWIDTH-1:0]            rowWrData,
   input  logic                           parityClr,
   output logic                           busy,
   output logic                           swapDone,
   output logic                           singular,
   output logic                           swapParity
);

   localparam int IW = prs_idx_w(MAT_SIZE);
   localparam logic [IW-1:0] LAST_ROW = IW'(MAT_SIZE - 1);

   prs_state_e          state_q, state_d;
   logic [IW-1:0]       tgt_row_q, tgt_row_d;
   logic [IW-1:0]       piv_row_q, piv_row_d;
   logic [ROWWIDTH-1:0] buf_a_q, buf_a_d;
   logic [ROWWIDTH-1:0] buf_b_q, buf_b_d;
   logic                rd_en_q, rd_en_d;
   logic [IW-1:0]       rd_addr_q, rd_addr_d;
   logic                wr_en_q, wr_en_d;
   logic [IW-1:0]       wr_addr_q, wr_addr_d;
   logic [ROWWIDTH-1:0] wr_dat_q, wr_dat_d;
   logic                singular_q, singular_d;
   logic                parity_q, parity_d;
   logic                accept;
   logic                bad_pivot;

   // Gating with reset_n keeps the acknowledge low while reset holds the FSM in IDLE.
   assign accept       = (state_q == IDLE) && matchDone && reset_n;
   assign bad_pivot    = error || (winnerIndex > LAST_ROW) || (winnerIndex < opCnt);

   assign matchDoneRst = accept;
   assign busy         = (state_q != IDLE);
   assign swapDone     = (state_q == DONE);
   assign rowRdEn      = rd_en_q;
   assign rowRdAddr    = rd_addr_q;
   assign rowWrEn      = wr_en_q;
   assign rowWrAddr    = wr_addr_q;
   assign rowWrData    = wr_dat_q;
   assign singular     = singular_q;
   assign swapParity   = parity_q;

   always_comb begin
      state_d    = state_q;
      tgt_row_d  = tgt_row_q;
      piv_row_d  = piv_row_q;
      buf_a_d    = buf_a_q;
      buf_b_d    = buf_b_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_dat_d   = wr_dat_q;
      singular_d = singular_q;
      parity_d   = parity_q;

      // Memory-facing outputs are registered, so each is loaded on entry to the state that uses it.
      case (state_q)
         IDLE: begin
            if (accept) begin
               tgt_row_d = opCnt;
               piv_row_d = winnerIndex;
               if (bad_pivot) begin
                  singular_d = 1'b1;
                  state_d    = DONE;
               end else if (winnerIndex == opCnt) begin
                  state_d = DONE;
               end else begin
                  state_d   = RD_A;
                  rd_en_d   = 1'b1;
                  rd_addr_d = opCnt;
               end
            end
         end
         RD_A: begin
            state_d   = RD_B;
            rd_en_d   = 1'b1;
            rd_addr_d = piv_row_q;
         end
         RD_B: begin
            buf_a_d = rowRdData;
            state_d = CAP_B;
         end
         CAP_B: begin
            buf_b_d   = rowRdData;
            state_d   = WR_A;
            wr_en_d   = 1'b1;
            wr_addr_d = tgt_row_q;
            wr_dat_d  = buf_b_d;
         end
         WR_A: begin
            state_d   = WR_B;
            wr_en_d   = 1'b1;
            wr_addr_d = piv_row_q;
            wr_dat_d  = buf_a_q;
         end
         WR_B: begin
            parity_d = ~parity_q;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (parityClr) begin
         singular_d = 1'b0;
         parity_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         tgt_row_q  <= '0;
         piv_row_q  <= '0;
         buf_a_q    <= '0;
         buf_b_q    <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_dat_q   <= '0;
         singular_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tgt_row_q  <= tgt_row_d;
         piv_row_q  <= piv_row_d;
         buf_a_q    <= buf_a_d;
         buf_b_q    <= buf_b_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_dat_q   <= wr_dat_d;
         singular_q <= singular_d;
         parity_q   <= parity_d;
      end
   end

endmodule

// File: doc/pivot_row_swap.md
PIVOT_ROW_SWAP -- requirements
Module: pivotRowSwap

Interface
REQ-001 SHALL have parameter MAT_SIZE, default 5, matrix order N.
REQ-002 SHALL have parameter DATWIDTH, default 64, fixed-point element width.
REQ-003 SHALL have parameter ROWWIDTH, default 2*MAT_SIZE*DATWIDTH, one augmented row [A|I].
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 opCnt  in  $clog2(MAT_SIZE)+1  current elimination step (target row).
REQ-007 matchDone  in  1  pivot search complete (level, held until cleared).
REQ-008 error  in  1  pivot search found all-zero column.
REQ-009 winnerIndex  in  $clog2(MAT_SIZE)+1  pivot row index.
REQ-010 matchDoneRst  out  1  one-cycle pulse clearing upstream matchDone.
REQ-011 rowRdEn / rowRdAddr  out  1 / $clog2(MAT_SIZE)+1  row memory read request.
REQ-012 rowRdData  in  ROWWIDTH  read data, valid exactly 1 cycle after rowRdEn.
REQ-013 rowWrEn / rowWrAddr / rowWrData  out  1 / $clog2(MAT_SIZE)+1 / ROWWIDTH  row memory write.
REQ-014 parityClr  in  1  clears swapParity (new inversion).
REQ-015 busy  out  1  FSM not in IDLE.
REQ-016 swapDone  out  1  one-cycle completion pulse.
REQ-017 singular  out  1  sticky singular flag, valid with swapDone.
REQ-018 swapParity  out  1  parity of row exchanges performed (determinant sign).

Function
REQ-019 FSM states SHALL be IDLE, RD_A, RD_B, CAP_B, WR_A, WR_B, DONE.
REQ-020 In IDLE with matchDone=1: latch opCnt->tgtRow, winnerIndex->pivRow, pulse matchDoneRst same cycle.
REQ-021 Acceptance with error=1, or winnerIndex>MAT_SIZE-1, or winnerIndex<opCnt: go DONE, set singular, no memory access.
REQ-022 Acceptance with winnerIndex==opCnt: go DONE, no memory access, parity unchanged.
REQ-023 Otherwise: RD_A (rdEn, addr=tgtRow) -> RD_B (rdEn, addr=pivRow, capture rowRdData to bufA) -> CAP_B (capture rowRdData to bufB) -> WR_A (wrEn, addr=tgtRow, data=bufB) -> WR_B (wrEn, addr=pivRow, data=bufA) -> DONE.
REQ-024 swapParity SHALL toggle on the WR_B cycle.
REQ-025 DONE SHALL assert swapDone for exactly one cycle and return to IDLE next cycle.
REQ-026 Latency acceptance-edge to swapDone: 6 cycles for a swap, 1 cycle for skip/singular.
REQ-027 rowRdEn and rowWrEn SHALL never be asserted in the same cycle; at most one write per cycle.
REQ-028 matchDone while busy SHALL be ignored (not acknowledged) until IDLE.
REQ-029 Inputs opCnt/winnerIndex changing after acceptance SHALL NOT affect the operation in progress.
REQ-030 singular SHALL stay set until parityClr or reset; parityClr also clears swapParity; parityClr coincident with a WR_B toggle: clear wins.
REQ-031 Outputs rowRdAddr/rowWrAddr/rowWrData SHALL be registered; rowWrData unused when rowWrEn=0 may hold any value.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE; busy, swapDone, matchDoneRst, rowRdEn, rowWrEn, singular, swapParity = 0; addresses, bufA, bufB, rowWrData = 0.
REQ-033 Reset mid-swap SHALL abort with no further writes; a half-completed swap is not repaired.

Structure
REQ-034 Shared package SHALL hold the FSM state enum, MAT_SIZE/DATWIDTH defaults, and row-index width function/typedef, reused by columnScan neighbours.
REQ-035 Single module, no sub-module; row buffers are two ROWWIDTH registers.

Verification
REQ-036 N=5, opCnt=0, winner=3, rows r0=0x11.., r3=0x33..: -> after swapDone mem[0]=0x33.., mem[3]=0x11.., swapParity=1, swapDone at cycle 6.
REQ-037 opCnt=2, winner=2: -> swapDone 1 cycle after accept, no rowRdEn/rowWrEn, parity unchanged, singular=0.
REQ-038 error=1, winner=4: -> swapDone with singular=1, no memory traffic; singular held through next normal swap until parityClr.
REQ-039 matchDone held high across full swap: -> exactly one matchDoneRst pulse, second acceptance only after IDLE.
REQ-040 reset_n low during WR_A: -> outputs zero immediately, no WR_B write, IDLE after release.
REQ-041 Two consecutive swaps (0<->4, 1<->2) then parityClr coincident with second WR_B: -> swapParity=0.
